// File: rtl/wb_stage.sv
// Write-back stage of the 16-bit pipelined core.
// Selects the write-back source (ALU, formatted load data or link address).
// Waits for load data from the data-memory port, with a timeout.
// Drives the register-file write port and the retirement/bus-error pulses.
module wb_stage #(
    parameter int LD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_rd,
    input  logic        in_regwe,
    input  logic [1:0]  in_wb_sel,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_pc,
    input  logic        in_ld_byte,
    input  logic        in_ld_signed,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  WB_addr,
    output logic [15:0] WB_data,
    output logic        RegWe,
    output logic        retire,
    output logic [15:0] retire_pc,
    output logic        bus_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    // Value of the wait counter on the last cycle a load may still complete.
    localparam logic [7:0] TO_LAST = 8'(LD_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;

    // Pending-load context, captured when the load is accepted.
    logic [2:0]  r_ld_rd;
    logic        r_ld_regwe;
    logic [15:0] r_ld_pc;
    logic        r_ld_byte;
    logic        r_ld_signed;
    logic        r_ld_addr0;

    // Registered outputs.
    logic [2:0]  r_wb_addr;
    logic [15:0] r_wb_data;
    logic        r_regwe;
    logic        r_retire;
    logic [15:0] r_retire_pc;
    logic        r_bus_err;

    logic        w_accept;
    logic        w_is_load;
    logic [15:0] w_nl_data;
    logic [7:0]  w_lane;
    logic        w_fill;
    logic [15:0] w_ld_data;

    // in_ready is purely a function of state and reset, never of in_valid.
    assign in_ready  = rst_n & (r_state != WAIT_LD);
    assign w_accept  = in_valid & in_ready & ~clear;
    assign w_is_load = (in_wb_sel == SEL_LOAD);

    // Non-load data source: link address for 10, ALU result for 00 and 11.
    always_comb begin
        w_nl_data = in_alu;
        if (in_wb_sel == SEL_LINK) begin
            w_nl_data = in_pc + 16'd1;
        end
    end

    // Load data formatting: pick the byte lane from address bit 0, then extend.
    always_comb begin
        w_lane    = r_ld_addr0 ? mem_rdata[15:8] : mem_rdata[7:0];
        w_fill    = r_ld_signed & w_lane[7];
        w_ld_data = mem_rdata;
        if (r_ld_byte) begin
            w_ld_data = {{8{w_fill}}, w_lane};
        end
    end

    // Control FSM with registered write-back outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_ld_rd     <= 3'd0;
            r_ld_regwe  <= 1'b0;
            r_ld_pc     <= 16'd0;
            r_ld_byte   <= 1'b0;
            r_ld_signed <= 1'b0;
            r_ld_addr0  <= 1'b0;
            r_wb_addr   <= 3'd0;
            r_wb_data   <= 16'd0;
            r_regwe     <= 1'b0;
            r_retire    <= 1'b0;
            r_retire_pc <= 16'd0;
            r_bus_err   <= 1'b0;
        end else begin
            r_regwe   <= 1'b0;
            r_retire  <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // mem_rvalid is deliberately ignored here (stale or early data).
                    if (w_accept) begin
                        if (w_is_load) begin
                            r_ld_rd     <= in_rd;
                            r_ld_regwe  <= in_regwe;
                            r_ld_pc     <= in_pc;
                            r_ld_byte   <= in_ld_byte;
                            r_ld_signed <= in_ld_signed;
                            r_ld_addr0  <= in_alu[0];
                            r_cnt       <= 8'd0;
                            r_state     <= WAIT_LD;
                        end else begin
                            r_wb_addr   <= in_rd;
                            r_wb_data   <= w_nl_data;
                            r_regwe     <= in_regwe & (in_rd != 3'd0);
                            r_retire    <= 1'b1;
                            r_retire_pc <= in_pc;
                        end
                    end
                end
                WAIT_LD: begin
                    if (clear) begin
                        // Flush wins over data arriving in the same cycle.
                        r_state <= IDLE;
                    end else if (mem_rvalid) begin
                        r_wb_addr   <= r_ld_rd;
                        r_wb_data   <= w_ld_data;
                        r_regwe     <= r_ld_regwe & (r_ld_rd != 3'd0);
                        r_retire    <= 1'b1;
                        r_retire_pc <= r_ld_pc;
                        r_state     <= IDLE;
                    end else if (r_cnt == TO_LAST) begin
                        r_bus_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign WB_addr   = r_wb_addr;
    assign WB_data   = r_wb_data;
    assign RegWe     = r_regwe;
    assign retire    = r_retire;
    assign retire_pc = r_retire_pc;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expected values.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rd;
    logic        in_regwe;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu;
    logic [15:0] in_pc;
    logic        in_ld_byte;
    logic        in_ld_signed;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [2:0]  WB_addr;
    logic [15:0] WB_data;
    logic        RegWe;
    logic        retire;
    logic [15:0] retire_pc;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage #(.LD_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_regwe     (in_regwe),
        .in_wb_sel    (in_wb_sel),
        .in_alu       (in_alu),
        .in_pc        (in_pc),
        .in_ld_byte   (in_ld_byte),
        .in_ld_signed (in_ld_signed),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .WB_addr      (WB_addr),
        .WB_data      (WB_data),
        .RegWe        (RegWe),
        .retire       (retire),
        .retire_pc    (retire_pc),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] rd, input logic [1:0] sel, input logic [15:0] alu,
                           input logic [15:0] pc, input logic byt, input logic sgn);
        in_valid     = 1'b1;
        in_rd        = rd;
        in_regwe     = 1'b1;
        in_wb_sel    = sel;
        in_alu       = alu;
        in_pc        = pc;
        in_ld_byte   = byt;
        in_ld_signed = sgn;
    endtask

    initial begin
        rst_n = 0; clear = 0; in_valid = 0; in_rd = 0; in_regwe = 0; in_wb_sel = 0;
        in_alu = 0; in_pc = 0; in_ld_byte = 0; in_ld_signed = 0; mem_rvalid = 0; mem_rdata = 0;
        step(); step();
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_wb_addr", {13'd0, WB_addr}, 16'd0);
        check("rst_wb_data", WB_data, 16'h0000);
        check("rst_regwe", {15'd0, RegWe}, 16'd0);
        check("rst_retire", {15'd0, retire}, 16'd0);
        check("rst_retire_pc", retire_pc, 16'h0000);
        check("rst_bus_err", {15'd0, bus_err}, 16'd0);
        rst_n = 1; #1;
        check("rst_rel_ready", {15'd0, in_ready}, 16'd1);

        // ALU write to r3
        present(3'd3, 2'b00, 16'h1234, 16'h0010, 0, 0);
        step(); in_valid = 0;
        $display("txn alu rd=3 data=%h", WB_data);
        check("alu_addr", {13'd0, WB_addr}, 16'd3);
        check("alu_data", WB_data, 16'h1234);
        check("alu_regwe", {15'd0, RegWe}, 16'd1);
        check("alu_retire", {15'd0, retire}, 16'd1);
        check("alu_pc", retire_pc, 16'h0010);
        step();
        check("alu_regwe_drop", {15'd0, RegWe}, 16'd0);
        check("alu_retire_drop", {15'd0, retire}, 16'd0);
        check("alu_data_hold", WB_data, 16'h1234);

        // r0 write is suppressed but still retires; then link back-to-back
        present(3'd0, 2'b00, 16'h5555, 16'h0011, 0, 0);
        step();
        $display("txn r0 write regwe=%b retire=%b", RegWe, retire);
        check("r0_regwe", {15'd0, RegWe}, 16'd0);
        check("r0_retire", {15'd1 & 15'd0, retire}, 16'd1);
        present(3'd7, 2'b10, 16'h0000, 16'hFFFF, 0, 0);
        step(); in_valid = 0;
        $display("txn link rd=7 data=%h", WB_data);
        check("link_data", WB_data, 16'h0000);
        check("link_addr", {13'd0, WB_addr}, 16'd7);
        check("link_regwe", {15'd0, RegWe}, 16'd1);
        step();

        // Signed byte load, upper lane, data 3 cycles after accept; queued ALU behind
        present(3'd2, 2'b01, 16'h0101, 16'h0020, 1, 1);
        step();
        present(3'd4, 2'b00, 16'h4444, 16'h0021, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("bld_ready_low", {15'd0, in_ready}, 16'd0);
            check("bld_no_retire", {15'd0, retire}, 16'd0);
            step();
        end
        check("bld_ready_low3", {15'd0, in_ready}, 16'd0);
        mem_rvalid = 1; mem_rdata = 16'h80FF;
        step(); mem_rvalid = 0;
        $display("txn byte load rd=2 data=%h", WB_data);
        check("bld_data", WB_data, 16'hFF80);
        check("bld_addr", {13'd0, WB_addr}, 16'd2);
        check("bld_regwe", {15'd0, RegWe}, 16'd1);
        check("bld_pc", retire_pc, 16'h0020);
        check("bld_ready_back", {15'd0, in_ready}, 16'd1);
        step(); in_valid = 0;
        $display("txn queued alu rd=4 data=%h", WB_data);
        check("q_data", WB_data, 16'h4444);
        check("q_retire", {15'd0, retire}, 16'd1);

        // Word load, data one cycle after accept; following ALU retires next cycle
        present(3'd5, 2'b01, 16'h0100, 16'h0030, 0, 0);
        step();
        present(3'd6, 2'b00, 16'h6666, 16'h0031, 0, 0);
        mem_rvalid = 1; mem_rdata = 16'hBEEF;
        step(); mem_rvalid = 0;
        $display("txn word load rd=5 data=%h", WB_data);
        check("wld_data", WB_data, 16'hBEEF);
        check("wld_addr", {13'd0, WB_addr}, 16'd5);
        check("wld_regwe", {15'd0, RegWe}, 16'd1);
        step(); in_valid = 0;
        $display("txn alu rd=6 data=%h", WB_data);
        check("wld_next_data", WB_data, 16'h6666);
        check("wld_next_pc", retire_pc, 16'h0031);

        // Timeout: no data for 4 wait cycles
        present(3'd1, 2'b01, 16'h0000, 16'h0040, 0, 0);
        step(); in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("to_no_err_yet", {15'd0, bus_err}, 16'd0);
            step();
        end
        $display("txn load timeout bus_err=%b", bus_err);
        check("to_bus_err", {15'd0, bus_err}, 16'd1);
        check("to_no_regwe", {15'd0, RegWe}, 16'd0);
        check("to_no_retire", {15'd0, retire}, 16'd0);
        check("to_ready", {15'd0, in_ready}, 16'd1);
        step();
        check("to_err_pulse", {15'd0, bus_err}, 16'd0);

        // Data in the final allowed cycle completes normally
        present(3'd1, 2'b01, 16'h0000, 16'h0041, 0, 0);
        step(); in_valid = 0;
        step(); step(); step();
        mem_rvalid = 1; mem_rdata = 16'h1357;
        step(); mem_rvalid = 0;
        $display("txn late load rd=1 data=%h", WB_data);
        check("late_data", WB_data, 16'h1357);
        check("late_regwe", {15'd0, RegWe}, 16'd1);
        check("late_no_err", {15'd0, bus_err}, 16'd0);

        // Flush: rvalid in accept cycle ignored, clear in 2nd wait cycle, late data ignored
        present(3'd3, 2'b01, 16'h0000, 16'h0050, 0, 0);
        mem_rvalid = 1; mem_rdata = 16'hAAAA;
        step(); in_valid = 0; mem_rvalid = 0;
        check("fl_accept_rvalid_ign", {15'd0, retire}, 16'd0);
        step();
        clear = 1;
        step(); clear = 0;
        check("fl_ready", {15'd0, in_ready}, 16'd1);
        check("fl_no_regwe", {15'd0, RegWe}, 16'd0);
        mem_rvalid = 1; mem_rdata = 16'h9999;
        step(); mem_rvalid = 0;
        $display("txn flushed load regwe=%b retire=%b", RegWe, retire);
        check("fl_late_regwe", {15'd0, RegWe}, 16'd0);
        check("fl_late_retire", {15'd0, retire}, 16'd0);
        check("fl_data_hold", WB_data, 16'h1357);
        clear = 1;
        present(3'd7, 2'b00, 16'h7777, 16'h0060, 0, 0);
        step(); clear = 0; in_valid = 0;
        check("fl_drop_retire", {15'd0, retire}, 16'd0);
        check("fl_drop_data", WB_data, 16'h1357);
        for (int i = 0; i < 5; i++) begin
            check("fl_no_bus_err", {15'd0, bus_err}, 16'd0);
            step();
        end

        // Reset during WAIT_LD discards the pending load
        present(3'd2, 2'b01, 16'h0000, 16'h0070, 0, 0);
        step(); in_valid = 0;
        rst_n = 0;
        step();
        check("wrst_ready", {15'd0, in_ready}, 16'd0);
        check("wrst_data", WB_data, 16'h0000);
        check("wrst_pc", retire_pc, 16'h0000);
        rst_n = 1;
        mem_rvalid = 1; mem_rdata = 16'h5A5A;
        step(); mem_rvalid = 0;
        $display("txn reset in wait regwe=%b", RegWe);
        check("wrst_no_regwe", {15'd0, RegWe}, 16'd0);
        check("wrst_ready_back", {15'd0, in_ready}, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
